addr_seg_disp: RTL and testbench

Downstream consumer of the 4x4 cursor address stage, whose output is addr 1..16. Shows the current address as two decimal digits on a multiplexed common-anode 7-segment pair. Samples addr coherently once per scan frame, pulses on change, and blinks the decimal point after each cursor move as operator feedback. Out-of-range addresses display "--".

---
 rtl/addr_disp_pkg.sv | 21 ++
 rtl/seg7_decode.sv | 20 ++
 rtl/addr_seg_disp.sv | 135 +++++++++++++
 tb/tb_addr_seg_disp.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/addr_disp_pkg.sv
// Shared types and constants for the cursor-address 7-segment display.
package addr_disp_pkg;

  typedef enum logic {
    DIG_TENS = 1'b0,
    DIG_ONES = 1'b1
  } dig_state_e;

  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned ADDR_MIN = 1;
  localparam int unsigned ADDR_MAX = 16;

  // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_CODE [0:9] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg7_decode.sv
// Decimal digit to active-high 7-segment pattern; dash overrides blank overrides value.
module seg7_decode
  import addr_disp_pkg::*;
(
  input  logic [3:0] value,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    if (dash) begin
      seg_c = SEG_DASH;
    end else if (!blank && (value <= 4'd9)) begin
      seg_c = SEG_CODE[value];
    end
  end

endmodule

// File: rtl/addr_seg_disp.sv
// Two-digit multiplexed display of the cursor address with frame-coherent sampling,
// change pulse and a decimal-point blink after each move.
module addr_seg_disp
  import addr_disp_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 24000000,
  parameter int unsigned SCAN_HZ        = 1000,
  parameter int unsigned BLANK_CYC      = 24,
  parameter int unsigned BLINK_FRAMES   = 250,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
  input  logic              clk_24m,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  output logic [7:0]        seg,
  output logic [1:0]        dig,
  output logic              addr_chg
);

  localparam int unsigned SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int unsigned CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned HOLD_W   = (BLINK_FRAMES > 0) ? $clog2(BLINK_FRAMES + 1) : 1;

  logic [CNT_W-1:0]  cnt;
  logic [HOLD_W-1:0] hold;
  logic [ADDR_W-1:0] addr_q;
  dig_state_e        state;
  dig_state_e        state_next;

  logic              scan_tick_c;
  logic              frame_tick_c;
  logic              addr_valid_c;
  logic [3:0]        ones_c;
  logic [3:0]        dec_value_c;
  logic              dec_blank_c;
  logic              dec_dash_c;
  logic              dp_c;
  logic [1:0]        dig_on_c;
  logic [6:0]        seg7_c;

  assign scan_tick_c  = (cnt == CNT_W'(SCAN_DIV - 1));
  assign frame_tick_c = scan_tick_c && (state == DIG_ONES);
  assign addr_valid_c = (addr_q >= ADDR_W'(ADDR_MIN)) && (addr_q <= ADDR_W'(ADDR_MAX));
  assign ones_c       = (addr_q >= ADDR_W'(10)) ? 4'(addr_q - ADDR_W'(10)) : 4'(addr_q);

  // Digit-slot timebase
  always_ff @(posedge clk_24m) begin
    if (rst || scan_tick_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_24m) begin
    if (rst) begin
      state <= DIG_TENS;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (scan_tick_c) begin
      state_next = (state == DIG_TENS) ? DIG_ONES : DIG_TENS;
    end
  end

  always_comb begin
    dec_value_c = 4'd1;
    dec_blank_c = 1'b0;
    dec_dash_c  = !addr_valid_c;
    dp_c        = 1'b0;
    dig_on_c    = 2'b00;
    case (state)
      DIG_TENS: begin
        dec_blank_c = (addr_q < ADDR_W'(10));
        dig_on_c    = 2'b10;
      end
      DIG_ONES: begin
        dec_value_c = ones_c;
        dp_c        = addr_valid_c && (hold != '0);
        dig_on_c    = 2'b01;
      end
      default: ;
    endcase
  end

  seg7_decode u_decode (
    .value (dec_value_c),
    .blank (dec_blank_c),
    .dash  (dec_dash_c),
    .seg_c (seg7_c)
  );

  // Address sample at frame boundary; hold counter times the DP blink in frames
  always_ff @(posedge clk_24m) begin
    if (rst) begin
      addr_q   <= ADDR_W'(ADDR_MIN);
      addr_chg <= 1'b0;
      hold     <= '0;
    end else begin
      addr_chg <= 1'b0;
      if (frame_tick_c) begin
        addr_q   <= addr;
        addr_chg <= (addr != addr_q);
      end
      if (addr_chg) begin
        hold <= HOLD_W'(BLINK_FRAMES);
      end else if (frame_tick_c && (hold != '0)) begin
        hold <= hold - HOLD_W'(1);
      end
    end
  end

  // seg latches only at slot start so it never changes under an enabled digit
  always_ff @(posedge clk_24m) begin
    if (rst) begin
      seg <= {8{SEG_ACTIVE_LOW}};
      dig <= {2{DIG_ACTIVE_LOW}};
    end else begin
      if (cnt == '0) begin
        seg <= {dp_c, seg7_c} ^ {8{SEG_ACTIVE_LOW}};
      end
      if (cnt < CNT_W'(BLANK_CYC)) begin
        dig <= {2{DIG_ACTIVE_LOW}};
      end else begin
        dig <= dig_on_c ^ {2{DIG_ACTIVE_LOW}};
      end
    end
  end

endmodule

// File: tb/tb_addr_seg_disp.sv
// Scoreboard bench: a time-based reference model predicts each lit-digit window
// and each change pulse; an independent monitor matches them against the DUT.
module tb_addr_seg_disp;

  localparam int SLOT  = 10;
  localparam int FRAME = 2 * SLOT;
  localparam int BLANK = 2;
  localparam int BLINK = 3;

  typedef struct {
    int         start;
    logic [1:0] dig;
    logic [7:0] seg;
  } win_t;

  logic       clk_24m = 1'b0;
  logic       rst     = 1'b1;
  logic [4:0] addr    = 5'd1;
  logic [7:0] seg;
  logic [1:0] dig;
  logic       addr_chg;

  win_t wq[$];
  int   cq[$];
  int   cyc;
  int   n_vec;
  int   n_bad;
  int   aq;
  int   last_chg;

  win_t       cur;
  bit         in_win;
  logic [1:0] prev_dig;

  addr_seg_disp #(
    .CLK_HZ         (1000),
    .SCAN_HZ        (100),
    .BLANK_CYC      (2),
    .BLINK_FRAMES   (3),
    .SEG_ACTIVE_LOW (1'b1),
    .DIG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk_24m  (clk_24m),
    .rst      (rst),
    .addr     (addr),
    .seg      (seg),
    .dig      (dig),
    .addr_chg (addr_chg)
  );

  always #5 clk_24m = ~clk_24m;

  // Cycle index since the last reset edge
  always @(posedge clk_24m) cyc <= rst ? 0 : cyc + 1;

  function automatic logic [6:0] digit_code(input int d);
    case (d)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [7:0] exp_seg(input int a, input bit ones, input bit lit);
    logic [7:0] raw;
    if (a < 1 || a > 16)  raw = 8'h40;
    else if (!ones)       raw = (a >= 10) ? 8'h06 : 8'h00;
    else                  raw = {lit, digit_code(a % 10)};
    return ~raw;
  endfunction

  // Reference model: slot/frame derived from elapsed cycles
  always @(negedge clk_24m) begin
    int   s;
    int   f;
    bit   ones;
    bit   lit;
    win_t w;
    if (cyc == 0) begin
      aq       = 1;
      last_chg = -1000;
      wq.delete();
      cq.delete();
    end
    s    = cyc / SLOT;
    f    = cyc / FRAME;
    ones = (s % 2) == 1;
    if (cyc % SLOT == 0) begin
      lit     = ones && ((f - last_chg) < BLINK);
      w.start = cyc + BLANK + 1;
      w.dig   = ones ? 2'b10 : 2'b01;
      w.seg   = exp_seg(aq, ones, lit);
      wq.push_back(w);
    end
    if (cyc % FRAME == FRAME - 1) begin
      if (int'(addr) != aq) begin
        cq.push_back(cyc + 1);
        last_chg = f + 1;
      end
      aq = int'(addr);
    end
  end

  // Monitor
  always @(negedge clk_24m) begin
    win_t e;
    int   ec;
    if (cyc == 0) begin
      n_vec++;
      if (seg !== 8'hFF || dig !== 2'b11 || addr_chg !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_out: got seg=%h dig=%b chg=%b, want seg=ff dig=11 chg=0",
                 seg, dig, addr_chg);
      end
      in_win   = 1'b0;
      prev_dig = 2'b11;
    end else begin
      while (wq.size() > 0 && wq[0].start < cyc) begin
        e = wq.pop_front();
        n_vec++;
        n_bad++;
        $display("FAIL window_missing: no window at cycle %0d, want dig=%b seg=%h",
                 e.start, e.dig, e.seg);
      end
      if (dig !== 2'b11 && prev_dig === 2'b11) begin
        n_vec++;
        if (wq.size() == 0) begin
          n_bad++;
          $display("FAIL window_unexpected: cycle %0d dig=%b seg=%h, none expected",
                   cyc, dig, seg);
          in_win = 1'b0;
        end else begin
          e = wq.pop_front();
          if (e.start != cyc || dig !== e.dig || seg !== e.seg) begin
            n_bad++;
            $display("FAIL window: got cycle=%0d dig=%b seg=%h, want cycle=%0d dig=%b seg=%h",
                     cyc, dig, seg, e.start, e.dig, e.seg);
          end
          cur    = e;
          in_win = 1'b1;
        end
      end else if (dig !== 2'b11 && in_win) begin
        n_vec++;
        if (dig !== cur.dig || seg !== cur.seg) begin
          n_bad++;
          $display("FAIL window_hold: cycle %0d got dig=%b seg=%h, want dig=%b seg=%h",
                   cyc, dig, seg, cur.dig, cur.seg);
        end
      end else if (dig === 2'b11) begin
        in_win = 1'b0;
      end
      prev_dig = dig;

      while (cq.size() > 0 && cq[0] < cyc) begin
        ec = cq.pop_front();
        n_vec++;
        n_bad++;
        $display("FAIL chg_missing: got no pulse at cycle %0d, want addr_chg=1", ec);
      end
      if (addr_chg !== 1'b0) begin
        n_vec++;
        if (cq.size() == 0) begin
          n_bad++;
          $display("FAIL chg_unexpected: got addr_chg=%b at cycle %0d, want 0", addr_chg, cyc);
        end else begin
          ec = cq.pop_front();
          if (ec != cyc) begin
            n_bad++;
            $display("FAIL chg_time: got pulse at cycle %0d, want cycle %0d", cyc, ec);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_24m);
    #2;
  endtask

  task automatic wait_pos(input int p);
    int i;
    i = 0;
    do begin
      tick(1);
      i++;
    end while (cyc % FRAME != p && i < 100);
    if (cyc % FRAME != p) begin
      n_vec++;
      n_bad++;
      $display("FAIL wait_pos: got frame position %0d, want %0d", cyc % FRAME, p);
    end
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst   = 1'b1;
    addr  = 5'd1;
    tick(3);
    rst = 1'b0;
    tick(2 * FRAME);

    // 1 -> 16 mid-frame, then watch the blink expire
    wait_pos(7);
    addr = 5'd16;
    tick(6 * FRAME);

    // single digit, then invalid values
    addr = 5'd5;
    tick(2 * FRAME);
    addr = 5'd0;
    tick(2 * FRAME);
    addr = 5'd17;
    tick(2 * FRAME);

    // changes in consecutive frames
    addr = 5'd5;
    tick(2 * FRAME);
    wait_pos(1);
    addr = 5'd6;
    wait_pos(1);
    addr = 5'd7;
    tick(6 * FRAME);

    // reset mid ONES slot while the hold counter is part-way down
    addr = 5'd3;
    wait_pos(1);
    wait_pos(1);
    wait_pos(14);
    pulse_rst();
    tick(3 * FRAME);

    // sub-frame glitch between boundaries
    addr = 5'd5;
    tick(3 * FRAME);
    wait_pos(3);
    addr = 5'd9;
    tick(8);
    addr = 5'd5;
    tick(3 * FRAME);

    for (int i = 0; i < 80; i++) begin
      tick(int'($urandom_range(1, 30)));
      if ($urandom_range(0, 15) == 0)     pulse_rst();
      else if ($urandom_range(0, 3) == 0) addr = 5'($urandom_range(0, 31));
      else                                addr = 5'($urandom_range(1, 16));
    end

    wait_pos(5);
    n_vec++;
    if (cq.size() != 0) begin
      n_bad++;
      $display("FAIL chg_drain: got %0d pending pulses, want 0", cq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
